// File: rtl/math_pkg.sv
`default_nettype none
// ============================================================================
// Module   : math_pkg
// Brief    : Shared widths and shift-clamp helper for the math datapath blocks.
// Revision : 1.0 - initial release
// ============================================================================
package math_pkg;

  localparam int SUM_WIDTH   = 97;
  localparam int SHIFT_WIDTH = 7;
  localparam int SHIFT_MAX   = 96;

  function automatic logic [SHIFT_WIDTH-1:0] clamp_shift(input logic [SHIFT_WIDTH-1:0] shift);
    return (shift > SHIFT_WIDTH'(SHIFT_MAX)) ? SHIFT_WIDTH'(SHIFT_MAX) : shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/math_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : math_sat_cnt
// Brief    : Sticky saturation flag plus saturating event counter; a clear in
//            the same cycle as an event is applied before the event is counted.
// Revision : 1.0 - initial release
// ============================================================================
module math_sat_cnt
  import math_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_event,
  input  logic                 i_clr,
  output logic                 o_sticky,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else if (i_event) begin
      r_sticky <= 1'b1;
      if (i_clr) begin
        r_count <= CNT_WIDTH'(1);
      end else if (r_count != '1) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end else if (i_clr) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end
  end

  assign o_sticky = r_sticky;
  assign o_count  = r_count;

endmodule
`default_nettype wire

// File: rtl/math_round_sat_97.sv
`default_nettype none
// ============================================================================
// Module   : math_round_sat_97
// Brief    : Two-stage shift / round / saturate stage for the 97-bit adder sum.
//            MATH_ROUND_SAT_CONVERGENT_EN selects round-half-even (default:
//            round-half-up).
// Revision : 1.0 - initial release
// ============================================================================
module math_round_sat_97
  import math_pkg::*;
#(
  parameter int OUT_WIDTH = 48,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_ena,
  input  logic                   i_din_valid,
  input  logic [SUM_WIDTH-1:0]   i_din,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [OUT_WIDTH-1:0]   o_dout,
  output logic                   o_dout_valid,
  output logic                   o_sat,
  output logic                   o_sat_sticky,
  input  logic                   i_sat_clr,
  output logic [CNT_WIDTH-1:0]   o_sat_count
);

  // ---------------- stage 1: shift, guard, sticky ----------------
  logic [SHIFT_WIDTH-1:0] w_s;
  logic [SUM_WIDTH-1:0]   w_q;
  logic                   w_g;

  logic [SUM_WIDTH-1:0]   r_q;
  logic                   r_g;
  logic                   r_v1;

  assign w_s = clamp_shift(i_shift);
  assign w_q = i_din >> w_s;
  assign w_g = (w_s != '0) ? i_din[w_s - 7'd1] : 1'b0;

`ifdef MATH_ROUND_SAT_CONVERGENT_EN
  logic [SUM_WIDTH-1:0] w_tmask;
  logic                 w_t;
  logic                 r_t;

  // Bits strictly below the guard bit decide whether a tie is exact.
  assign w_tmask = (w_s > 7'd1) ? ((SUM_WIDTH'(1) << (w_s - 7'd1)) - SUM_WIDTH'(1)) : '0;
  assign w_t     = |(i_din & w_tmask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t <= 1'b0;
    end else if (i_ena) begin
      r_t <= w_t;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q  <= '0;
      r_g  <= 1'b0;
      r_v1 <= 1'b0;
    end else if (i_ena) begin
      r_q  <= w_q;
      r_g  <= w_g;
      r_v1 <= i_din_valid;
    end
  end

  // ---------------- stage 2: round and saturate ----------------
  logic                 w_r;
  logic [SUM_WIDTH:0]   w_y;
  logic                 w_ovf;
  logic [OUT_WIDTH-1:0] w_dout;
  logic                 w_sat;

`ifdef MATH_ROUND_SAT_CONVERGENT_EN
  assign w_r = r_g & (r_t | r_q[0]);
`else
  assign w_r = r_g;
`endif

  assign w_y    = {1'b0, r_q} + {{SUM_WIDTH{1'b0}}, w_r};
  assign w_ovf  = |w_y[SUM_WIDTH:OUT_WIDTH];
  assign w_dout = w_ovf ? '1 : w_y[OUT_WIDTH-1:0];
  assign w_sat  = w_ovf & r_v1;

  logic [OUT_WIDTH-1:0] r_dout;
  logic                 r_dout_valid;
  logic                 r_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sat        <= 1'b0;
    end else if (i_ena) begin
      r_dout       <= w_dout;
      r_dout_valid <= r_v1;
      r_sat        <= w_sat;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_sat        = r_sat;

  // An event is counted only on the edge that registers the clipped sample.
  math_sat_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_sat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_event  (i_ena & w_sat),
    .i_clr    (i_sat_clr),
    .o_sticky (o_sat_sticky),
    .o_count  (o_sat_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_math_round_sat_97.sv
`default_nettype none
// ============================================================================
// Module   : tb_math_round_sat_97
// Brief    : Self-checking bench: directed literal cases plus random stimulus
//            against a behavioural divide-and-round reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_math_round_sat_97;

  localparam int OW = 48;
  localparam int CW = 4;
`ifdef MATH_ROUND_SAT_CONVERGENT_EN
  localparam bit CONV = 1'b1;
`else
  localparam bit CONV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_ena = 1'b0;
  logic          i_din_valid = 1'b0;
  logic [96:0]   i_din = '0;
  logic [6:0]    i_shift = '0;
  logic          i_sat_clr = 1'b0;
  logic [OW-1:0] o_dout;
  logic          o_dout_valid;
  logic          o_sat;
  logic          o_sat_sticky;
  logic [CW-1:0] o_sat_count;

  math_round_sat_97 #(.OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ena        (i_ena),
    .i_din_valid  (i_din_valid),
    .i_din        (i_din),
    .i_shift      (i_shift),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid),
    .o_sat        (o_sat),
    .o_sat_sticky (o_sat_sticky),
    .i_sat_clr    (i_sat_clr),
    .o_sat_count  (o_sat_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: divide by 2^s, round the remainder, clip to OW bits.
  task automatic ref_calc(input logic [96:0] d, input int sh, output logic [OW-1:0] o, output bit sat);
    int s;
    logic [127:0] dd, q, rem, half, y;
    bit up;
    s   = (sh > 96) ? 96 : sh;
    dd  = {31'd0, d};
    q   = dd >> s;
    rem = dd - (q << s);
    up  = 1'b0;
    if (s > 0) begin
      half = 128'd1 << (s - 1);
      if (rem > half) up = 1'b1;
      else if (rem == half) up = CONV ? q[0] : 1'b1;
    end
    y = q + {127'd0, up};
    if (y >= (128'd1 << OW)) begin
      o = '1;
      sat = 1'b1;
    end else begin
      o = y[OW-1:0];
      sat = 1'b0;
    end
  endtask

  bit            m_ready = 1'b0;
  logic [OW-1:0] s1_dout;
  bit            s1_sat;
  bit            s1_valid;
  logic [OW-1:0] m_dout;
  bit            m_vld, m_sat, m_sticky;
  int            m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready  = 1'b1;
      s1_dout  = '0;
      s1_sat   = 1'b0;
      s1_valid = 1'b0;
      m_dout   = '0;
      m_vld    = 1'b0;
      m_sat    = 1'b0;
      m_sticky = 1'b0;
      m_cnt    = 0;
    end else begin
      if (i_sat_clr) begin
        m_sticky = 1'b0;
        m_cnt    = 0;
      end
      if (i_ena && s1_valid && s1_sat) begin
        m_sticky = 1'b1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (i_ena) begin
        m_dout = s1_dout;
        m_vld  = s1_valid;
        m_sat  = s1_valid && s1_sat;
        ref_calc(i_din, int'(i_shift), s1_dout, s1_sat);
        s1_valid = i_din_valid;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("dout", 128'(o_dout), 128'(m_dout));
      chk("dout_valid", 128'(o_dout_valid), 128'(m_vld));
      chk("sat", 128'(o_sat), 128'(m_sat));
      chk("sat_sticky", 128'(o_sat_sticky), 128'(m_sticky));
      chk("sat_count", 128'(o_sat_count), 128'(m_cnt));
    end
  end

  // Drive one cycle of inputs at a falling edge; returns after the next falling edge.
  task automatic cyc(input bit ena, input bit vld, input logic [96:0] d, input logic [6:0] sh, input bit clr);
    i_ena = ena;
    i_din_valid = vld;
    i_din = d;
    i_shift = sh;
    i_sat_clr = clr;
    @(negedge clk);
  endtask

  logic [OW-1:0] outs[$];
  logic [OW-1:0] ones = '1;
  logic [96:0]   big;

  initial begin
    @(negedge clk);
    cyc(0, 0, '0, '0, 0);
    rst_n = 1'b1;
    chk("reset dout", 128'(o_dout), 128'd0);
    chk("reset count", 128'(o_sat_count), 128'd0);

    cyc(1, 1, 97'h1234, 7'd0, 0);
    cyc(1, 0, '0, '0, 0);
    chk("pass dout", 128'(o_dout), 128'h1234);
    chk("pass valid", 128'(o_dout_valid), 128'd1);
    chk("pass sat", 128'(o_sat), 128'd0);

    cyc(1, 1, 97'h5, 7'd1, 0);
    cyc(1, 1, 97'h7, 7'd1, 0);
    chk("half 2.5", 128'(o_dout), CONV ? 128'd2 : 128'd3);
    cyc(1, 0, '0, '0, 0);
    chk("half 3.5", 128'(o_dout), 128'd4);

    big = 97'd1 << 96;
    cyc(1, 1, big, 7'd0, 0);
    cyc(1, 0, '0, '0, 0);
    chk("carry dout", 128'(o_dout), 128'(ones));
    chk("carry sat", 128'(o_sat), 128'd1);
    chk("carry sticky", 128'(o_sat_sticky), 128'd1);
    chk("carry count", 128'(o_sat_count), 128'd1);
    cyc(1, 0, '0, '0, 1);
    chk("clr count", 128'(o_sat_count), 128'd0);
    chk("clr sticky", 128'(o_sat_sticky), 128'd0);

    big = (97'd1 << 49) - 97'd1;
    cyc(1, 1, big, 7'd1, 0);
    cyc(1, 0, '0, '0, 0);
    chk("round sat dout", 128'(o_dout), 128'(ones));
    chk("round sat", 128'(o_sat), 128'd1);

    big = (97'd3 << 95);
    cyc(1, 1, big, 7'd127, 0);
    cyc(1, 1, big, 7'd96, 0);
    chk("shift127", 128'(o_dout), 128'd2);
    cyc(1, 0, '0, '0, 0);
    chk("shift96", 128'(o_dout), 128'd2);

    // Stream with a three-cycle stall after the second sample.
    outs.delete();
    cyc(1, 1, 97'd10, 7'd0, 0); if (o_dout_valid) outs.push_back(o_dout);
    cyc(1, 1, 97'd20, 7'd0, 0); if (o_dout_valid) outs.push_back(o_dout);
    for (int i = 0; i < 3; i++) cyc(0, 1, 97'd30, 7'd0, 0);
    cyc(1, 1, 97'd30, 7'd0, 0); if (o_dout_valid) outs.push_back(o_dout);
    cyc(1, 1, 97'd40, 7'd0, 0); if (o_dout_valid) outs.push_back(o_dout);
    cyc(1, 0, '0, 7'd0, 0);     if (o_dout_valid) outs.push_back(o_dout);
    cyc(1, 0, '0, 7'd0, 0);     if (o_dout_valid) outs.push_back(o_dout);
    chk("stall count", 128'(outs.size()), 128'd4);
    if (outs.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("stall order", 128'(outs[i]), 128'((i + 1) * 10));
    end

    // Clear coincident with a saturation event.
    big = 97'd1 << 96;
    cyc(1, 1, big, 7'd0, 0);
    cyc(1, 1, big, 7'd0, 0);
    cyc(1, 0, '0, 7'd0, 1);
    chk("clr+event count", 128'(o_sat_count), 128'd1);
    chk("clr+event sticky", 128'(o_sat_sticky), 128'd1);

    for (int i = 0; i < 20; i++) cyc(1, 1, big, 7'd0, 0);
    cyc(1, 0, '0, 7'd0, 0);
    cyc(1, 0, '0, 7'd0, 0);
    chk("count saturates", 128'(o_sat_count), 128'd15);

    // Reset with two samples in flight.
    cyc(1, 1, 97'd77, 7'd0, 0);
    cyc(1, 1, 97'd88, 7'd0, 0);
    rst_n = 1'b0;
    cyc(1, 1, 97'd99, 7'd0, 0);
    rst_n = 1'b1;
    chk("rst dout", 128'(o_dout), 128'd0);
    chk("rst valid", 128'(o_dout_valid), 128'd0);
    chk("rst count", 128'(o_sat_count), 128'd0);
    cyc(1, 0, '0, 7'd0, 0);
    chk("flush valid a", 128'(o_dout_valid), 128'd0);
    cyc(1, 0, '0, 7'd0, 0);
    chk("flush valid b", 128'(o_dout_valid), 128'd0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      logic [127:0] r;
      logic [6:0]   sh;
      r = {$urandom, $urandom, $urandom, $urandom};
      r = r >> $urandom_range(0, 127);
      sh = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8));
      rst_n = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, r[96:0], sh,
          $urandom_range(0, 29) == 0);
    end
    rst_n = 1'b1;
    cyc(0, 0, '0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
